// File: rtl/valid_code_sequencer.sv
// valid_code_sequencer: steps through the valid code set {3,4,6,8,9,10,13} on a valid/ready interface
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, dir          : begin a sequence (IDLE only), direction latched on start (1 = descending)
//   step, auto_en       : manual advance on step rise, or timed advance on prescaler tick when auto_en=1
//   abort               : return to IDLE, overrides everything else
//   out_ready           : consumer accepts code while code_valid is high
//   code, code_valid    : offered code (set member or 0) and its valid flag
//   index, busy, done   : table index, not-IDLE flag, one-cycle end-of-sequence pulse (LOOP=0)
module valid_code_sequencer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 27,
    parameter bit LOOP     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step,
    input  logic       auto_en,
    input  logic       dir,
    input  logic       abort,
    input  logic       out_ready,
    output logic [3:0] code,
    output logic       code_valid,
    output logic [2:0] index,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, PRESENT, WAIT, DONE} state_t;
    localparam logic [CNT_W-1:0] cnt_max = CNT_W'(TICK_DIV - 1);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             step_q, dir_q;
    logic             tick, rise, adv, last;
    logic [2:0]       nxt;
    function automatic logic [3:0] code_of(input logic [2:0] i);
        case (i)
            3'd0:    code_of = 4'd3;
            3'd1:    code_of = 4'd4;
            3'd2:    code_of = 4'd6;
            3'd3:    code_of = 4'd8;
            3'd4:    code_of = 4'd9;
            3'd5:    code_of = 4'd10;
            default: code_of = 4'd13;
        endcase
    endfunction
    always_comb begin
        tick = cnt == cnt_max;
        rise = step & ~step_q;
        // auto_en picks the advance source each cycle; the other source is simply ignored
        adv  = auto_en ? tick : rise;
        last = dir_q ? (index == 3'd0) : (index == 3'd6);
        nxt  = last ? (dir_q ? 3'd6 : 3'd0) : (dir_q ? index - 3'd1 : index + 3'd1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            code       <= 4'd0;
            code_valid <= 1'b0;
            index      <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            step_q <= step;
            if (abort) begin
                state      <= IDLE;
                cnt        <= '0;
                code       <= 4'd0;
                code_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        dir_q      <= dir;
                        index      <= dir ? 3'd6 : 3'd0;
                        code       <= dir ? 4'd13 : 4'd3;
                        code_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= PRESENT;
                    end
                    PRESENT: if (out_ready) begin
                        code_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                    WAIT: begin
                        // wrap keeps the count within 0..TICK_DIV-1 while waiting for a manual step
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (adv) begin
                            cnt <= '0;
                            if (last && !LOOP) begin
                                code  <= 4'd0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                index      <= nxt;
                                code       <= code_of(nxt);
                                code_valid <= 1'b1;
                                state      <= PRESENT;
                            end
                        end
                    end
                    default: begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
